// File: rtl/ddr_bw_seq.sv
// Test sequencer for the DDR bandwidth-test AXI master: programs the read/write
// control registers, watches the B and read-stream handshakes and accumulates per-direction cycle counts.
module ddr_bw_seq #(
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = 7,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [31:0]      base_addr,
    input  logic [31:0]      stride,
    input  logic [31:0]      rd_len,
    input  logic [31:0]      wr_nburst,
    input  logic [15:0]      n_iter,
    input  logic [CNT_W-1:0] timeout,
    output logic             rstart,
    output logic [31:0]      raddr,
    output logic [31:0]      rlength,
    input  logic             rd_idle,
    output logic             wstart,
    output logic [31:0]      waddr,
    output logic [31:0]      wnburst,
    input  logic             bvalid,
    input  logic             bready,
    input  logic [1:0]       bresp,
    input  logic             rd_tvalid,
    input  logic             rd_tready,
    input  logic             rd_tlast,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [15:0]      bresp_err_cnt,
    output logic [CNT_W-1:0] wr_cycles,
    output logic [CNT_W-1:0] rd_cycles,
    output logic [15:0]      iter_cnt
);

    if ((DATA_WIDTH % 8) != 0 || BURST_LENGTH < 0 || BURST_LENGTH > 255 || CNT_W < 2) begin : g_param_check
        $error("ddr_bw_seq: unsupported parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_PULSE,
        S_W_WAIT,
        S_R_SETUP,
        S_R_PULSE,
        S_R_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]       mode_q;
    logic [31:0]      stride_q;
    logic [31:0]      rd_len_q;
    logic [31:0]      wr_nburst_q;
    logic [15:0]      n_iter_q;
    logic [CNT_W-1:0] timeout_q;
    logic [31:0]      cur_addr;
    logic [31:0]      bcnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             rd_last_seen;

    logic b_hs;
    logic r_last_hs;
    logic wr_done;
    logic rd_done;
    logic wait_expired;
    logic last_iter;
    logic accept;
    logic timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign wstart = (state == S_W_PULSE);
    assign rstart = (state == S_R_PULSE);
    assign done   = (state == S_DONE);
    assign busy   = (state != S_IDLE) && (state != S_DONE);

    // Completion counts a handshake landing in the same cycle; the read side
    // ignores rd_idle for two cycles so a stale idle from the last pass is never taken.
    always_comb begin
        next_state   = state;
        b_hs         = bvalid & bready;
        r_last_hs    = rd_tvalid & rd_tready & rd_tlast;
        wr_done      = (bcnt + 32'(b_hs)) == wr_nburst_q;
        rd_done      = (rd_last_seen || r_last_hs) && rd_idle && (wait_cnt >= CNT_W'(2));
        wait_expired = (timeout_q != '0) && (wait_cnt >= timeout_q - CNT_W'(1));
        last_iter    = (iter_cnt + 16'd1) == ((n_iter_q == 16'd0) ? 16'd1 : n_iter_q);
        accept       = ((state == S_IDLE) || (state == S_DONE)) && start;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) next_state = (mode == 2'd1) ? S_R_SETUP : S_W_SETUP;
            end
            S_W_SETUP: next_state = S_W_PULSE;
            S_W_PULSE: next_state = S_W_WAIT;
            S_W_WAIT: begin
                if (wr_done) begin
                    next_state = (mode_q >= 2'd2) ? S_R_SETUP : S_NEXT;
                end else if (wait_expired) begin
                    next_state  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_R_SETUP: next_state = S_R_PULSE;
            S_R_PULSE: next_state = S_R_WAIT;
            S_R_WAIT: begin
                if (rd_done) begin
                    next_state = S_NEXT;
                end else if (wait_expired) begin
                    next_state  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_NEXT: begin
                if (last_iter) next_state = S_DONE;
                else           next_state = (mode_q == 2'd1) ? S_R_SETUP : S_W_SETUP;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q        <= '0;
            stride_q      <= '0;
            rd_len_q      <= '0;
            wr_nburst_q   <= '0;
            n_iter_q      <= '0;
            timeout_q     <= '0;
            cur_addr      <= '0;
            bcnt          <= '0;
            wait_cnt      <= '0;
            rd_last_seen  <= 1'b0;
            raddr         <= '0;
            rlength       <= '0;
            waddr         <= '0;
            wnburst       <= '0;
            err_timeout   <= 1'b0;
            bresp_err_cnt <= '0;
            wr_cycles     <= '0;
            rd_cycles     <= '0;
            iter_cnt      <= '0;
        end else begin
            if (accept) begin
                mode_q        <= mode;
                stride_q      <= stride;
                rd_len_q      <= rd_len;
                wr_nburst_q   <= wr_nburst;
                n_iter_q      <= n_iter;
                timeout_q     <= timeout;
                cur_addr      <= base_addr;
                err_timeout   <= 1'b0;
                bresp_err_cnt <= '0;
                wr_cycles     <= '0;
                rd_cycles     <= '0;
                iter_cnt      <= '0;
            end
            case (state)
                S_W_SETUP: begin
                    waddr   <= cur_addr;
                    wnburst <= wr_nburst_q;
                    bcnt    <= '0;
                end
                S_W_PULSE: begin
                    wait_cnt  <= '0;
                    wr_cycles <= sat_inc_cnt(wr_cycles);
                end
                S_W_WAIT: begin
                    wr_cycles <= sat_inc_cnt(wr_cycles);
                    wait_cnt  <= sat_inc_cnt(wait_cnt);
                    if (b_hs) begin
                        bcnt <= bcnt + 32'd1;
                        if (bresp != 2'b00) bresp_err_cnt <= sat_inc16(bresp_err_cnt);
                    end
                end
                S_R_SETUP: begin
                    raddr   <= cur_addr;
                    rlength <= rd_len_q;
                end
                S_R_PULSE: begin
                    wait_cnt     <= '0;
                    rd_last_seen <= 1'b0;
                    rd_cycles    <= sat_inc_cnt(rd_cycles);
                end
                S_R_WAIT: begin
                    rd_cycles <= sat_inc_cnt(rd_cycles);
                    wait_cnt  <= sat_inc_cnt(wait_cnt);
                    if (r_last_hs) rd_last_seen <= 1'b1;
                end
                S_NEXT: begin
                    iter_cnt <= sat_inc16(iter_cnt);
                    cur_addr <= cur_addr + stride_q;
                end
                default: begin
                end
            endcase
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end

endmodule
